// File: rtl/pmp_pkg.sv
// rtl/pmp_pkg.sv - shared types for the PMP entry programmer
package pmp_pkg;

    localparam int ADDR_W = 32;
    localparam int K_W    = 6;

    typedef enum logic [1:0] {
        A_OFF   = 2'b00,
        A_TOR   = 2'b01,
        A_NA4   = 2'b10,
        A_NAPOT = 2'b11
    } pmp_amode_e;

    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        pmp_amode_e a;
        logic [2:0] perm;
    } pmp_cfg_t;

    typedef enum logic [1:0] {
        RSP_OK         = 2'b00,
        RSP_LOCKED     = 2'b01,
        RSP_BAD_SIZE   = 2'b10,
        RSP_MISALIGNED = 2'b11
    } prog_rsp_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ENCODE,
        S_WRITE,
        S_RESP
    } prog_state_e;

endpackage

// File: rtl/pmp_napot_mask_gen.sv
// rtl/pmp_napot_mask_gen.sv - iterative NAPOT mask builder, one mask bit per cycle
module pmp_napot_mask_gen
    import pmp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [K_W-1:0]    k,
    output logic              done,
    output logic [ADDR_W-1:0] mask
);

    logic [K_W-1:0] cnt_q;
    logic           busy_q;

    // done marks the cycle whose closing edge shifts in the last (k-1th) one
    assign done = busy_q && (cnt_q == K_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            mask   <= '0;
            cnt_q  <= k - K_W'(1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            mask  <= {mask[ADDR_W-2:0], 1'b1};
            cnt_q <= cnt_q - K_W'(1);
            if (cnt_q == K_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pmp_entry_programmer.sv
// rtl/pmp_entry_programmer.sv - validates protect-region requests and holds the pmpcfg/pmpaddr bank
module pmp_entry_programmer
    import pmp_pkg::*;
#(
    parameter  int NUM_ENTRIES = 16,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_clear,
    input  logic [IDX_W-1:0]          req_idx,
    input  logic [31:0]               req_base,
    input  logic [5:0]                req_size_log2,
    input  logic [2:0]                req_perm,
    input  logic                      req_lock,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_code,
    output logic [8*NUM_ENTRIES-1:0]  cfg_o,
    output logic [32*NUM_ENTRIES-1:0] addr_o
);

    prog_state_e     state_q, state_d;
    prog_rsp_e       code_q, code_d;
    logic            cap_clear, cap_lock;
    logic [IDX_W-1:0] cap_idx;
    logic [31:0]     cap_base;
    logic [5:0]      cap_k;
    logic [2:0]      cap_perm;
    logic            mask_start, mask_done;
    logic [31:0]     mask;
    logic [32:0]     align_mask;
    logic            misaligned;
    pmp_cfg_t        wr_cfg;
    logic [31:0]     wr_addr;
    pmp_cfg_t        cfg_q  [NUM_ENTRIES];
    logic [31:0]     addr_q [NUM_ENTRIES];

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_code  = code_q;

    // 33 bits so k=32 yields a full 32-bit alignment mask
    assign align_mask = (33'd1 << cap_k) - 33'd1;
    assign misaligned = |(cap_base & align_mask[31:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= RSP_OK;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        mask_start = 1'b0;
        case (state_q)
            S_IDLE: if (req_valid) state_d = S_CHECK;
            S_CHECK: begin
                state_d = S_RESP;
                if (cfg_q[cap_idx].l) begin
                    code_d = RSP_LOCKED;
                end else if (cap_clear) begin
                    code_d  = RSP_OK;
                    state_d = S_WRITE;
                end else if (cap_k < 6'd2 || cap_k > 6'd32) begin
                    code_d = RSP_BAD_SIZE;
                end else if (misaligned) begin
                    code_d = RSP_MISALIGNED;
                end else begin
                    code_d = RSP_OK;
                    if (cap_k == 6'd2) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d    = S_ENCODE;
                        mask_start = 1'b1;
                    end
                end
            end
            S_ENCODE: if (mask_done) state_d = S_WRITE;
            S_WRITE:  state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_clear <= 1'b0;
            cap_lock  <= 1'b0;
            cap_idx   <= '0;
            cap_base  <= '0;
            cap_k     <= '0;
            cap_perm  <= '0;
        end else if (state_q == S_IDLE && req_valid) begin
            cap_clear <= req_clear;
            cap_lock  <= req_lock;
            cap_idx   <= req_idx;
            cap_base  <= req_base;
            cap_k     <= req_size_log2;
            cap_perm  <= req_perm;
        end
    end

    pmp_napot_mask_gen u_mask_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mask_start),
        .k     (cap_k),
        .done  (mask_done),
        .mask  (mask)
    );

    always_comb begin
        wr_cfg      = '0;
        wr_addr     = '0;
        if (!cap_clear) begin
            wr_cfg.l    = cap_lock;
            wr_cfg.perm = cap_perm;
            if (cap_k == 6'd2) begin
                wr_cfg.a = A_NA4;
                wr_addr  = cap_base;
            end else begin
                wr_cfg.a = A_NAPOT;
                wr_addr  = cap_base | mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else if (state_q == S_WRITE) begin
            cfg_q[cap_idx]  <= wr_cfg;
            addr_q[cap_idx] <= wr_addr;
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_bank_out
        assign cfg_o[8*g +: 8]   = cfg_q[g];
        assign addr_o[32*g +: 32] = addr_q[g];
    end

endmodule

// File: tb/tb_pmp_entry_programmer.sv
// tb/tb_pmp_entry_programmer.sv - randomized self-checking bench for pmp_entry_programmer
module tb_pmp_entry_programmer;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_clear = 1'b0;
    logic [3:0]    req_idx = '0;
    logic [31:0]   req_base = '0;
    logic [5:0]    req_size_log2 = '0;
    logic [2:0]    req_perm = '0;
    logic          req_lock = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [1:0]    rsp_code;
    logic [8*N-1:0]  cfg_o;
    logic [32*N-1:0] addr_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  cfg_m  [N];
    logic [31:0] addr_m [N];

    always #5 clk = ~clk;

    pmp_entry_programmer #(.NUM_ENTRIES(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_clear     (req_clear),
        .req_idx       (req_idx),
        .req_base      (req_base),
        .req_size_log2 (req_size_log2),
        .req_perm      (req_perm),
        .req_lock      (req_lock),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_code      (rsp_code),
        .cfg_o         (cfg_o),
        .addr_o        (addr_o)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            cfg_m[i]  = 8'h00;
            addr_m[i] = 32'h0;
        end
    endtask

    task automatic check_bank(input string tag);
        logic [511:0] ec, ea;
        ec = '0;
        ea = '0;
        for (int i = 0; i < N; i++) begin
            ec[8*i +: 8]   = cfg_m[i];
            ea[32*i +: 32] = addr_m[i];
        end
        chk({tag, "_cfg"}, 512'(cfg_o), ec);
        chk({tag, "_addr"}, 512'(addr_o), ea);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, check code, latency, bank and handshake against the reference rules.
    task automatic do_req(input bit clr, input int idx, input logic [31:0] base, input int k,
                          input logic [2:0] perm, input bit lk, input int hold);
        int exp_code, exp_lat, lat;
        longint unsigned low;
        if (cfg_m[idx][7]) exp_code = 1;
        else if (clr) exp_code = 0;
        else if (k < 2 || k > 32) exp_code = 2;
        else if ((64'(base) & ((64'd1 << k) - 64'd1)) != 0) exp_code = 3;
        else exp_code = 0;
        if (exp_code != 0) exp_lat = 2;
        else if (clr || k == 2) exp_lat = 3;
        else exp_lat = 2 + k;
        if (exp_code == 0) begin
            if (clr) begin
                cfg_m[idx]  = 8'h00;
                addr_m[idx] = 32'h0;
            end else begin
                cfg_m[idx] = {lk, 2'b00, (k == 2) ? 2'b10 : 2'b11, perm};
                low = (64'd1 << (k - 1)) - 64'd1;
                addr_m[idx] = (k == 2) ? base : (base | low[31:0]);
            end
        end

        chk("req_ready_idle", 512'(req_ready), 512'(1));
        req_valid     = 1'b1;
        req_clear     = clr;
        req_idx       = 4'(idx);
        req_base      = base;
        req_size_log2 = 6'(k);
        req_perm      = perm;
        req_lock      = lk;
        rsp_ready     = (hold == 0);
        step();
        req_valid     = 1'b0;
        req_clear     = 1'($urandom);
        req_idx       = 4'($urandom);
        req_base      = $urandom;
        req_size_log2 = 6'($urandom);
        req_perm      = 3'($urandom);
        req_lock      = 1'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("latency", 512'(lat), 512'(exp_lat));
        chk("rsp_code", 512'(rsp_code), 512'(exp_code));
        check_bank("bank");
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 512'(rsp_valid), 512'(1));
            chk("hold_code", 512'(rsp_code), 512'(exp_code));
            chk("hold_ready", 512'(req_ready), 512'(0));
        end
        rsp_ready = 1'b1;
        step();
        chk("post_ready", 512'(req_ready), 512'(1));
        chk("post_valid", 512'(rsp_valid), 512'(0));
    endtask

    task automatic reset_mid_encode();
        int seen;
        rsp_ready     = 1'b1;
        req_valid     = 1'b1;
        req_clear     = 1'b0;
        req_idx       = 4'd7;
        req_base      = 32'h0010_0000;
        req_size_log2 = 6'd20;
        req_perm      = 3'b011;
        req_lock      = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_rsp_valid", 512'(rsp_valid), 512'(0));
        chk("rst_rsp_code", 512'(rsp_code), 512'(0));
        chk("rst_req_ready", 512'(req_ready), 512'(1));
        check_bank("rst_bank");
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            step();
            if (rsp_valid) seen++;
        end
        chk("rst_no_rsp", 512'(seen), 512'(0));
        check_bank("rst_bank_after");
    endtask

    initial begin
        int k, idx, r;
        logic [31:0] base;
        longint unsigned lm;

        model_reset();
        repeat (3) step();
        chk("reset_req_ready", 512'(req_ready), 512'(1));
        chk("reset_rsp_valid", 512'(rsp_valid), 512'(0));
        chk("reset_rsp_code", 512'(rsp_code), 512'(0));
        check_bank("reset");
        rst_n = 1'b1;
        step();

        do_req(0, 0, 32'h2000_0010, 2,  3'b011, 0, 0);
        chk("na4_cfg0", 512'(cfg_o[7:0]), 512'(8'h13));
        chk("na4_addr0", 512'(addr_o[31:0]), 512'(32'h2000_0010));
        do_req(0, 3, 32'h8000_1000, 12, 3'b101, 0, 0);
        chk("napot_cfg3", 512'(cfg_o[31:24]), 512'(8'h1D));
        chk("napot_addr3", 512'(addr_o[127:96]), 512'(32'h8000_17FF));
        do_req(0, 1, 32'h0000_1000, 1,  3'b001, 0, 0);
        do_req(0, 1, 32'h0000_1004, 4,  3'b001, 0, 0);
        do_req(0, 1, 32'h0000_1000, 33, 3'b001, 0, 0);
        do_req(0, 9, 32'h0000_0000, 32, 3'b111, 0, 0);
        chk("k32_addr9", 512'(addr_o[319:288]), 512'(32'h7FFF_FFFF));
        do_req(0, 9, 32'h0000_0100, 3,  3'b001, 0, 0);
        do_req(0, 5, 32'h0000_0100, 2,  3'b001, 1, 0);
        do_req(0, 5, 32'h0000_0200, 2,  3'b111, 0, 0);
        do_req(1, 5, 32'h0,         0,  3'b000, 0, 0);
        do_req(0, 6, 32'h0000_4000, 8,  3'b110, 0, 0);
        do_req(0, 6, 32'h0000_8000, 10, 3'b010, 0, 10);
        do_req(1, 6, 32'h0,         0,  3'b000, 0, 0);
        reset_mid_encode();

        for (int n = 0; n < 160; n++) begin
            idx = $urandom_range(0, N - 1);
            r = $urandom_range(0, 9);
            if (r == 0) k = $urandom_range(0, 40);
            else if (r == 1) k = 32;
            else k = $urandom_range(2, 16);
            lm = (k >= 32) ? 64'hFFFF_FFFF : ((64'd1 << k) - 64'd1);
            base = $urandom;
            if ($urandom_range(0, 3) != 0) base = base & ~lm[31:0];
            do_req($urandom_range(0, 7) == 0, idx, base, k, 3'($urandom),
                   $urandom_range(0, 24) == 0, $urandom_range(0, 3));
            if (n == 80) begin
                rst_n = 1'b0;
                step();
                model_reset();
                rst_n = 1'b1;
                step();
                check_bank("mid_reset");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
